// File: rtl/alu_exec_pkg.sv
// ============================================================================
// Module   : alu_exec_pkg
// Brief    : Shared widths, FSM state type and ALU opcodes for alu_exec_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_exec_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int CTRL_W = 4;
  localparam int NREGS  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [CTRL_W-1:0] OP_ADD = 4'b0000;
  localparam logic [CTRL_W-1:0] OP_SUB = 4'b0001;
  localparam logic [CTRL_W-1:0] OP_AND = 4'b0010;
  localparam logic [CTRL_W-1:0] OP_OR  = 4'b0011;
  localparam logic [CTRL_W-1:0] OP_NOT = 4'b0100;
  localparam logic [CTRL_W-1:0] OP_XOR = 4'b0101;
  localparam logic [CTRL_W-1:0] OP_NOR = 4'b0110;
  localparam logic [CTRL_W-1:0] OP_SLL = 4'b0111;
  localparam logic [CTRL_W-1:0] OP_SRL = 4'b1000;
  localparam logic [CTRL_W-1:0] OP_SRA = 4'b1001;
  localparam logic [CTRL_W-1:0] OP_ROL = 4'b1010;
  localparam logic [CTRL_W-1:0] OP_ROR = 4'b1011;
  localparam logic [CTRL_W-1:0] OP_EQ  = 4'b1100;

endpackage

`default_nettype wire

// File: rtl/alu_exec_regfile.sv
// ============================================================================
// Module   : alu_exec_regfile
// Brief    : 8x8 register file, two async read ports, writeback + load write
//            ports (writeback wins on address collision), r0 reads zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_regfile
  import alu_exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_a_addr,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [DATA_W-1:0] rd_b_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // Load applied first so a same-address writeback overrides it.
  always_comb begin
    regs_d = regs_q;
    if (ld_en) regs_d[ld_addr] = ld_data;
    if (wb_en) regs_d[wb_addr] = wb_data;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd_a_data = (rd_a_addr == '0) ? '0 : regs_q[rd_a_addr];
  assign rd_b_data = (rd_b_addr == '0) ? '0 : regs_q[rd_b_addr];

endmodule

`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
// ============================================================================
// Module   : alu_exec_ctrl
// Brief    : IDLE/EXEC/RESP front end feeding an external 8-bit ALU and
//            writing its result back. Optional macro ALU_EXEC_ZERO_FLAG_EN
//            adds a registered res_zero output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_ctrl
  import alu_exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [ADDR_W-1:0] in_rx,
  input  logic [ADDR_W-1:0] in_ry,
  input  logic [ADDR_W-1:0] in_rw,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_carry
`ifdef ALU_EXEC_ZERO_FLAG_EN
  ,
  output logic              res_zero
`endif
);

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [ADDR_W-1:0] rx_q, rx_d, ry_q, ry_d, rw_q, rw_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_carry_q, res_carry_d;
  logic              res_valid_q, res_valid_d;
  logic              in_ready_q, in_ready_d;
`ifdef ALU_EXEC_ZERO_FLAG_EN
  logic              res_zero_q, res_zero_d;
`endif

  logic              exec;
  logic [DATA_W-1:0] rd_x, rd_y;

  assign exec = (state_q == EXEC);

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    rx_d        = rx_q;
    ry_d        = ry_q;
    rw_d        = rw_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
`ifdef ALU_EXEC_ZERO_FLAG_EN
    res_zero_d  = res_zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          ctrl_d  = in_ctrl;
          rx_d    = in_rx;
          ry_d    = in_ry;
          rw_d    = in_rw;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_data_d  = alu_out;
        res_carry_d = alu_carry;
`ifdef ALU_EXEC_ZERO_FLAG_EN
        res_zero_d  = (alu_out == '0);
`endif
        state_d     = RESP;
      end
      RESP: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered decodes of the next state.
    in_ready_d  = (state_d == IDLE);
    res_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ctrl_q      <= '0;
      rx_q        <= '0;
      ry_q        <= '0;
      rw_q        <= '0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef ALU_EXEC_ZERO_FLAG_EN
      res_zero_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      rx_q        <= rx_d;
      ry_q        <= ry_d;
      rw_q        <= rw_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_valid_q <= res_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef ALU_EXEC_ZERO_FLAG_EN
      res_zero_q  <= res_zero_d;
`endif
    end
  end

  alu_exec_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_a_addr (rx_q),
    .rd_a_data (rd_x),
    .rd_b_addr (ry_q),
    .rd_b_data (rd_y),
    .wb_en     (exec),
    .wb_addr   (rw_q),
    .wb_data   (alu_out),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  assign alu_ctrl  = exec ? ctrl_q : '0;
  assign alu_x     = exec ? rd_x   : '0;
  assign alu_y     = exec ? rd_y   : '0;

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
`ifdef ALU_EXEC_ZERO_FLAG_EN
  assign res_zero  = res_zero_q;
`endif

endmodule

`default_nettype wire
